alu_exec_stage: RTL and testbench

Multi-cycle execute/write-back stage directly downstream of the 8x12-bit register file. It takes an opcode and three register indices and drives the file's read addresses. It captures readData1/readData2 after the file's one-cycle registered read, computes the result, and writes it back through the file's we/writeAddr/writeData. MUL is a 12-iteration shift-add; all other ops take one EXEC cycle.

---
 rtl/alu_exec_stage_if.sv | 24 ++
 rtl/alu_exec_stage.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Register-file side bus of the execute stage: registered read addresses, returned
// read data and the single write port.
interface alu_exec_stage_if #(
    parameter int WIDTH = 12,
    parameter int AW    = 3
);
    logic [AW-1:0]    read1Addr;
    logic [AW-1:0]    read2Addr;
    logic [WIDTH-1:0] readData1;
    logic [WIDTH-1:0] readData2;
    logic             we;
    logic [AW-1:0]    writeAddr;
    logic [WIDTH-1:0] writeData;

    modport master (
        output read1Addr, read2Addr, we, writeAddr, writeData,
        input  readData1, readData2
    );

    modport slave (
        input  read1Addr, read2Addr, we, writeAddr, writeData,
        output readData1, readData2
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Multi-cycle execute/write-back stage: reads two registers, computes one ALU op
// (MUL by WIDTH-step shift-add) and writes the result back with flags.
module alu_exec_stage #(
    parameter int WIDTH = 12,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [AW-1:0]        src1,
    input  logic [AW-1:0]        src2,
    input  logic [AW-1:0]        dest,
    alu_exec_stage_if.master     rf,
    output logic                 busy,
    output logic                 carry,
    output logic                 zero,
    output logic                 ovf
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RWAIT = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] WB    = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int CW = $clog2(WIDTH);

    logic [2:0]         state;
    logic [2:0]         op_q;
    logic [AW-1:0]      dest_q;
    logic [2*WIDTH-1:0] a_q;     // widened so MUL can shift the multiplicand left in place
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   a_lo;
    logic [3:0]         amt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_lo     = a_q[WIDTH-1:0];
        amt      = b_q[3:0];
        sum      = {1'b0, a_lo} + {1'b0, b_q};
        diff     = {1'b0, a_lo} - {1'b0, b_q};
        shl_w    = {1'b0, a_lo} << amt;
        shr_w    = {a_lo, 1'b0} >> amt;
        acc_next = acc_q + (b_q[0] ? a_q : '0);
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        case (op_q)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_lo[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_lo[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a_lo[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_lo[WIDTH-1]);
            end
            OP_AND: res = a_lo & b_q;
            OP_OR:  res = a_lo | b_q;
            OP_XOR: res = a_lo ^ b_q;
            OP_SHL: begin
                if (int'(amt) < WIDTH) begin
                    res   = shl_w[WIDTH-1:0];
                    res_c = shl_w[WIDTH];
                end
            end
            OP_SHR: begin
                if (int'(amt) < WIDTH) begin
                    res   = shr_w[WIDTH:1];
                    res_c = shr_w[0];
                end
            end
            default: begin
                res   = acc_next[WIDTH-1:0];
                res_c = |acc_next[2*WIDTH-1:WIDTH];
                res_v = res_c;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // Datapath registers are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= '0;
            dest_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            rf.read1Addr <= '0;
            rf.read2Addr <= '0;
            rf.writeAddr <= '0;
            rf.writeData <= '0;
            rf.we        <= 1'b0;
            busy         <= 1'b0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q         <= op;
                        dest_q       <= dest;
                        rf.read1Addr <= src1;
                        rf.read2Addr <= src2;
                        busy         <= 1'b1;
                        state        <= RADDR;
                    end
                end
                RADDR: state <= RWAIT;
                RWAIT: begin
                    a_q   <= {{WIDTH{1'b0}}, rf.readData1};
                    b_q   <= rf.readData2;
                    acc_q <= '0;
                    cnt_q <= '0;
                    state <= EXEC;
                end
                EXEC: begin
                    if (op_q == OP_MUL && cnt_q != CW'(WIDTH - 1)) begin
                        acc_q <= acc_next;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        rf.writeData <= res;
                        rf.writeAddr <= dest_q;
                        rf.we        <= 1'b1;
                        carry        <= res_c;
                        zero         <= (res == '0);
                        ovf          <= res_v;
                        state        <= WB;
                    end
                end
                WB: begin
                    rf.we <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural register file, directed plan cases,
// randomized ops against an integer reference model, busy-start and reset aborts.
module tb_alu_exec_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [2:0] src1 = '0, src2 = '0, dest = '0;
    logic       busy, carry, zero, ovf;

    int total = 0;
    int bad   = 0;

    int ref_mem [8];
    int obs_wd, obs_c, obs_z, obs_v;

    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = '0;
    logic [11:0] pre_data = '0;
    logic [11:0] rf_mem [8];

    alu_exec_stage_if #(.WIDTH(12), .AW(3)) rf_bus ();

    alu_exec_stage #(.WIDTH(12), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src1(src1), .src2(src2), .dest(dest), .rf(rf_bus),
        .busy(busy), .carry(carry), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Register file with a one-cycle registered read; not reset, so data survives aborts.
    always @(posedge clk) begin
        if (pre_we) rf_mem[pre_addr] <= pre_data;
        else if (rf_bus.we) rf_mem[rf_bus.writeAddr] <= rf_bus.writeData;
        rf_bus.readData1 <= rf_mem[rf_bus.read1Addr];
        rf_bus.readData2 <= rf_mem[rf_bus.read2Addr];
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int sgn(input int x);
        return (x >= 2048) ? x - 4096 : x;
    endfunction

    function automatic void alu_model(input int o, input int a, input int b,
                                      output int r, output int c, output int v);
        int p, amt, s;
        r = 0; c = 0; v = 0;
        amt = b % 16;
        case (o)
            0: begin
                p = a + b; r = p % 4096; c = (p >= 4096);
                s = sgn(a) + sgn(b); v = (s > 2047 || s < -2048);
            end
            1: begin
                r = (a - b + 4096) % 4096; c = (a < b);
                s = sgn(a) - sgn(b); v = (s > 2047 || s < -2048);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: if (amt == 0) r = a;
               else if (amt < 12) begin r = (a << amt) % 4096; c = (a >> (12 - amt)) & 1; end
            6: if (amt == 0) r = a;
               else if (amt < 12) begin r = a >> amt; c = (a >> (amt - 1)) & 1; end
            default: begin p = a * b; r = p % 4096; c = (p >= 4096); v = c; end
        endcase
    endfunction

    task automatic preload(input int addr, input int val);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 3'(addr); pre_data = 12'(val);
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[addr] = val;
    endtask

    task automatic run_op(input int o, input int s1, input int s2, input int d);
        int er, ec, ev, lat, exp_lat;
        bit got;
        alu_model(o, ref_mem[s1], ref_mem[s2], er, ec, ev);
        exp_lat = (o == 7) ? 14 : 3;
        @(negedge clk);
        start = 1'b1; op = 3'(o); src1 = 3'(s1); src2 = 3'(s2); dest = 3'(d);
        @(posedge clk); #1;
        total++; if (busy !== 1'b1 || rf_bus.read1Addr !== 3'(s1) || rf_bus.read2Addr !== 3'(s2)) begin
            bad++; $display("FAIL issue op=%0d: busy=%b r1=%0d r2=%0d want busy=1 r1=%0d r2=%0d",
                            o, busy, rf_bus.read1Addr, rf_bus.read2Addr, s1, s2);
        end
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); src1 = 3'($urandom); src2 = 3'($urandom); dest = 3'($urandom);
        got = 0; lat = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (rf_bus.we === 1'b1) begin got = 1; lat = cyc; break; end
            total++; if (busy !== 1'b1) begin
                bad++; $display("FAIL busy_hold op=%0d cyc=%0d: busy=%b want 1", o, cyc, busy);
            end
        end
        total++; if (!got || lat != exp_lat) begin
            bad++; $display("FAIL latency op=%0d: got we at %0d (seen=%0d) want %0d", o, lat, got, exp_lat);
        end
        obs_wd = int'(rf_bus.writeData); obs_c = int'(carry); obs_z = int'(zero); obs_v = int'(ovf);
        total++; if (rf_bus.writeAddr !== 3'(d) || rf_bus.writeData !== 12'(er)) begin
            bad++; $display("FAIL result op=%0d a=%0h b=%0h: addr=%0d data=%03h want addr=%0d data=%03h",
                            o, ref_mem[s1], ref_mem[s2], rf_bus.writeAddr, rf_bus.writeData, d, er);
        end
        total++; if (carry !== 1'(ec) || zero !== (er == 0) || ovf !== 1'(ev)) begin
            bad++; $display("FAIL flags op=%0d a=%0h b=%0h: c=%b z=%b v=%b want c=%0d z=%0d v=%0d",
                            o, ref_mem[s1], ref_mem[s2], carry, zero, ovf, ec, er == 0, ev);
        end
        ref_mem[d] = er;
        @(posedge clk); #1;
        total++; if (rf_bus.we !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL wb_end op=%0d: we=%b busy=%b want 0 0", o, rf_bus.we, busy);
        end
        total++; if (carry !== 1'(ec) || zero !== (er == 0) || ovf !== 1'(ev) || rf_mem[d] !== 12'(er)) begin
            bad++; $display("FAIL hold op=%0d: c=%b z=%b v=%b r%0d=%03h want c=%0d v=%0d r=%03h",
                            o, carry, zero, ovf, d, rf_mem[d], ec, ev, er);
        end
    endtask

    task automatic expect_const(input string name, input int wd, input int c, input int z, input int v);
        total++; if (obs_wd != wd || obs_c != c || obs_z != z || obs_v != v) begin
            bad++; $display("FAIL %s: data=%03h c=%0d z=%0d v=%0d want data=%03h c=%0d z=%0d v=%0d",
                            name, obs_wd, obs_c, obs_z, obs_v, wd, c, z, v);
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy !== 1'b0 || rf_bus.we !== 1'b0 || rf_bus.writeData !== 12'h0 ||
                     rf_bus.writeAddr !== 3'd0 || rf_bus.read1Addr !== 3'd0 ||
                     rf_bus.read2Addr !== 3'd0 || carry !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL reset_state: busy=%b we=%b wd=%03h wa=%0d r1=%0d r2=%0d c=%b z=%b v=%b want all 0",
                            busy, rf_bus.we, rf_bus.writeData, rf_bus.writeAddr,
                            rf_bus.read1Addr, rf_bus.read2Addr, carry, zero, ovf);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || rf_bus.we !== 1'b0) begin
            bad++; $display("FAIL idle_no_start: busy=%b we=%b want 0 0", busy, rf_bus.we);
        end
    endtask

    task automatic test_directed();
        preload(0, 30); preload(1, 40);
        run_op(0, 0, 1, 2); expect_const("add_30_40", 12'h046, 0, 0, 0);
        run_op(1, 0, 1, 3); expect_const("sub_30_40", 12'hFF6, 1, 0, 0);
        run_op(1, 0, 0, 4); expect_const("sub_self", 12'h000, 0, 1, 0);
        run_op(7, 0, 1, 4); expect_const("mul_30_40", 12'h4B0, 0, 0, 0);
        preload(5, 12'h0FF); preload(6, 12'h020);
        run_op(7, 5, 6, 7); expect_const("mul_ovf", 12'hFE0, 1, 0, 1);
        preload(5, 12'h5C0); preload(6, 12'h3C0); preload(7, 13);
        run_op(0, 5, 6, 2); expect_const("add_ovf", 12'h980, 0, 0, 1);
        run_op(4, 5, 6, 2); expect_const("xor", 12'h600, 0, 0, 0);
        run_op(5, 5, 7, 2); expect_const("shl_13", 12'h000, 0, 1, 0);
        preload(7, 3);
        run_op(6, 5, 7, 2); expect_const("shr_3", 12'h0B8, 0, 0, 0);
        run_op(0, 5, 6, 5); expect_const("src_is_dest", 12'h980, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) preload(i, int'($urandom_range(0, 4095)));
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 9) preload(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_start_while_busy();
        int pulses, first, er, ec, ev;
        bit dropped;
        preload(0, 30); preload(1, 40); preload(3, 12'h111);
        alu_model(7, 30, 40, er, ec, ev);
        pulses = 0; first = 0; dropped = 0;
        @(negedge clk);
        start = 1'b1; op = 3'd7; src1 = 3'd0; src2 = 3'd1; dest = 3'd2;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = (cyc == 6 || cyc == 7);
            op = 3'd0; dest = 3'd3;
            @(posedge clk); #1;
            if (rf_bus.we === 1'b1) begin
                pulses++;
                if (first == 0) begin first = cyc; obs_wd = int'(rf_bus.writeData); end
            end
            if (busy !== 1'b1 && pulses == 0) dropped = 1;
        end
        ref_mem[2] = er;
        total++; if (pulses != 1 || first != 14) begin
            bad++; $display("FAIL busy_start_pulses: pulses=%0d first=%0d want 1 at 14", pulses, first);
        end
        total++; if (dropped) begin
            bad++; $display("FAIL busy_start_busy: busy dropped=%0d want 0", dropped);
        end
        total++; if (obs_wd != er || rf_mem[3] !== 12'h111) begin
            bad++; $display("FAIL busy_start_data: wd=%03h r3=%03h want wd=%03h r3=111", obs_wd, rf_mem[3], er);
        end
    endtask

    task automatic test_reset_mid();
        preload(3, 100); preload(4, 200); preload(5, 12'h123);
        for (int phase = 0; phase < 2; phase++) begin
            @(negedge clk);
            start = 1'b1; op = 3'd0; src1 = 3'd3; src2 = 3'd4; dest = 3'd5;
            @(posedge clk);
            @(negedge clk); start = 1'b0;
            repeat (phase == 0 ? 2 : 3) @(posedge clk);
            #1;
            if (phase == 1) begin
                total++; if (rf_bus.we !== 1'b1) begin
                    bad++; $display("FAIL abort_reach_wb: we=%b want 1", rf_bus.we);
                end
            end
            #2 rst_n = 1'b0;
            #1;
            total++; if (busy !== 1'b0 || rf_bus.we !== 1'b0 || rf_bus.writeData !== 12'h0 ||
                         rf_bus.read1Addr !== 3'd0 || carry !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
                bad++; $display("FAIL abort_%0d_outputs: busy=%b we=%b wd=%03h r1=%0d c=%b z=%b v=%b want 0",
                                phase, busy, rf_bus.we, rf_bus.writeData, rf_bus.read1Addr, carry, zero, ovf);
            end
            @(posedge clk);
            @(negedge clk); rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            total++; if (rf_mem[5] !== 12'h123 || busy !== 1'b0) begin
                bad++; $display("FAIL abort_%0d_nowrite: r5=%03h busy=%b want 123 0", phase, rf_mem[5], busy);
            end
        end
        run_op(0, 3, 4, 5); expect_const("after_abort", 300, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
